// File: rtl/watch_cmd_pkg.sv
// Shared constants for the watch command decoder: ASCII command bytes,
// mode levels and echo FSM state encoding.
package watch_cmd_pkg;

    localparam logic [7:0] CMD_SEC  = 8'h73;
    localparam logic [7:0] CMD_MIN  = 8'h6D;
    localparam logic [7:0] CMD_HOUR = 8'h68;
    localparam logic [7:0] CMD_RUN  = 8'h72;
    localparam logic [7:0] CMD_CLR  = 8'h63;
    localparam logic [7:0] CMD_MODE = 8'h77;

    localparam logic MODE_WATCH = 1'b0;
    localparam logic MODE_SW    = 1'b1;

    typedef enum logic [1:0] {
        E_IDLE,
        E_START,
        E_WAIT_BUSY,
        E_WAIT_DONE
    } echo_state_t;

    // Maps 'A'..'Z' onto 'a'..'z' when folding is enabled.
    function automatic logic [7:0] fold_case(input logic [7:0] b, input logic en);
        if (en && (b >= 8'h41) && (b <= 8'h5A)) begin
            return b | 8'h20;
        end
        return b;
    endfunction

endpackage

// File: rtl/watch_cmd_decoder_pend_pulse_ch.sv
// One plus channel: saturating pending counter feeding a registered
// single-cycle pulse, draining at most one request per cycle.
module pend_pulse_ch #(
    parameter int unsigned PEND_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       clr,
    output logic       pulse
);

    localparam logic [PEND_W:0] CAP = (PEND_W + 1)'((1 << PEND_W) - 1);

    logic [PEND_W-1:0] pend;
    logic [PEND_W-1:0] pend_nxt;
    logic [PEND_W:0]   sum;
    logic [PEND_W:0]   rem;
    logic              issue;

    always_comb begin
        sum      = (PEND_W + 1)'(pend) + (PEND_W + 1)'(req);
        issue    = (sum != '0);
        rem      = sum - (PEND_W + 1)'(issue);
        pend_nxt = (rem > CAP) ? CAP[PEND_W-1:0] : rem[PEND_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= issue;
            pend  <= clr ? '0 : pend_nxt;
        end
    end

endmodule

// File: rtl/watch_cmd_decoder.sv
// Merges UART command bytes and button pulses into watch/stopwatch control
// pulses. Define WATCH_CMD_ECHO_EN to echo accepted command bytes.
module watch_cmd_decoder
    import watch_cmd_pkg::*;
#(
    parameter int unsigned PEND_W    = 2,
    parameter logic        CASE_FOLD = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    input  logic       i_btn_sec,
    input  logic       i_btn_min,
    input  logic       i_btn_hour,
    input  logic       i_btn_mode,
    output logic       o_sec_plus,
    output logic       o_min_plus,
    output logic       o_hour_plus,
    output logic       o_run_stop,
    output logic       o_clear,
    output logic       o_mode,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_busy
);

    logic [7:0] cmd;
    logic       hit_sec, hit_min, hit_hour, hit_run, hit_clr, hit_mode;
    logic       watch, toggle, accepted;
    logic [1:0] req_sec, req_min, req_hour;

    always_comb begin
        cmd      = fold_case(i_rx_data, CASE_FOLD);
        hit_sec  = i_rx_done && (cmd == CMD_SEC);
        hit_min  = i_rx_done && (cmd == CMD_MIN);
        hit_hour = i_rx_done && (cmd == CMD_HOUR);
        hit_run  = i_rx_done && (cmd == CMD_RUN);
        hit_clr  = i_rx_done && (cmd == CMD_CLR);
        hit_mode = i_rx_done && (cmd == CMD_MODE);
        // Gating looks at the mode before any toggle in this same cycle.
        watch    = (o_mode == MODE_WATCH);
        toggle   = hit_mode | i_btn_mode;
        req_sec  = watch ? (2'(hit_sec)  + 2'(i_btn_sec))  : 2'b00;
        req_min  = watch ? (2'(hit_min)  + 2'(i_btn_min))  : 2'b00;
        req_hour = watch ? (2'(hit_hour) + 2'(i_btn_hour)) : 2'b00;
        accepted = (watch && (hit_sec || hit_min || hit_hour))
                 || (!watch && (hit_run || hit_clr)) || hit_mode;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_mode     <= MODE_WATCH;
            o_run_stop <= 1'b0;
            o_clear    <= 1'b0;
        end else begin
            o_mode     <= o_mode ^ toggle;
            o_run_stop <= !watch && hit_run;
            o_clear    <= !watch && hit_clr;
        end
    end

    pend_pulse_ch #(.PEND_W(PEND_W)) u_sec (
        .clk(clk), .rst_n(rst), .req(req_sec), .clr(toggle), .pulse(o_sec_plus)
    );
    pend_pulse_ch #(.PEND_W(PEND_W)) u_min (
        .clk(clk), .rst_n(rst), .req(req_min), .clr(toggle), .pulse(o_min_plus)
    );
    pend_pulse_ch #(.PEND_W(PEND_W)) u_hour (
        .clk(clk), .rst_n(rst), .req(req_hour), .clr(toggle), .pulse(o_hour_plus)
    );

`ifdef WATCH_CMD_ECHO_EN
    echo_state_t state, state_nxt;
    logic        buf_valid;
    logic [7:0]  buf_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= E_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The buffer stays full until the transmitter finishes, so a command
    // accepted during an echo in flight is not echoed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if ((state == E_WAIT_DONE) && !i_tx_busy) begin
            buf_valid <= 1'b0;
        end else if (accepted && !buf_valid) begin
            buf_valid <= 1'b1;
            buf_data  <= i_rx_data;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            E_IDLE:      if (buf_valid && !i_tx_busy) state_nxt = E_START;
            E_START:     state_nxt = E_WAIT_BUSY;
            E_WAIT_BUSY: if (i_tx_busy) state_nxt = E_WAIT_DONE;
            E_WAIT_DONE: if (!i_tx_busy) state_nxt = E_IDLE;
            default:     state_nxt = E_IDLE;
        endcase
    end

    always_comb begin
        o_tx_start = (state == E_START);
        o_tx_data  = (state == E_START) ? buf_data : '0;
    end
`else
    logic unused_echo;
    assign unused_echo = i_tx_busy ^ accepted;
    assign o_tx_start  = 1'b0;
    assign o_tx_data   = '0;
`endif

endmodule

// File: tb/tb_watch_cmd_decoder.sv
// Directed self-checking bench for watch_cmd_decoder; echo checks run
// only when WATCH_CMD_ECHO_EN is defined.
module tb_watch_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_btn_sec, i_btn_min, i_btn_hour, i_btn_mode;
    logic       o_sec_plus, o_min_plus, o_hour_plus, o_run_stop, o_clear, o_mode;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       i_tx_busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    watch_cmd_decoder #(.PEND_W(2), .CASE_FOLD(1'b1)) dut (
        .clk(clk), .rst(rst),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .i_btn_sec(i_btn_sec), .i_btn_min(i_btn_min),
        .i_btn_hour(i_btn_hour), .i_btn_mode(i_btn_mode),
        .o_sec_plus(o_sec_plus), .o_min_plus(o_min_plus),
        .o_hour_plus(o_hour_plus), .o_run_stop(o_run_stop),
        .o_clear(o_clear), .o_mode(o_mode),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .i_tx_busy(i_tx_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rx(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
    endtask

    task automatic idle_inputs();
        i_rx_done  = 1'b0;
        i_rx_data  = 8'h00;
        i_btn_sec  = 1'b0;
        i_btn_min  = 1'b0;
        i_btn_hour = 1'b0;
        i_btn_mode = 1'b0;
    endtask

    // Packs all pulse outputs plus mode into one byte for compact checks.
    function automatic logic [7:0] outs();
        return {2'b00, o_mode, o_clear, o_run_stop, o_hour_plus, o_min_plus, o_sec_plus};
    endfunction

    task automatic wait_start(input string tag, input logic [7:0] exp_data);
        logic seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_start"}, 8'(seen), 8'h01);
        chk({tag, "_data"}, o_tx_data, exp_data);
        tick();
        chk({tag, "_one_cycle"}, 8'(o_tx_start), 8'h00);
    endtask

    task automatic tx_handshake();
        i_tx_busy = 1'b1;
        tick();
        i_tx_busy = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int unsigned cnt;
        rst       = 1'b0;
        i_tx_busy = 1'b0;
        idle_inputs();

        // Reset state
        repeat (3) tick();
        chk("reset_outs", outs(), 8'h00);
        chk("reset_tx_start", 8'(o_tx_start), 8'h00);
        chk("reset_tx_data", o_tx_data, 8'h00);
        rst = 1'b1;

        // 1: single 's' gives exactly one sec pulse one cycle later
        repeat (9) tick();
        rx(8'h73);
        tick();
        idle_inputs();
        chk("t1_sec_pulse", outs(), 8'h01);
        tick();
        chk("t1_sec_done", outs(), 8'h00);

        // Unknown byte is ignored
        rx(8'h78);
        tick();
        idle_inputs();
        chk("bad_byte", outs(), 8'h00);

        // 2: button + folded 'M' together drain over two cycles
        rx(8'h4D);
        i_btn_min = 1'b1;
        tick();
        idle_inputs();
        chk("t2_min_1", outs(), 8'h02);
        tick();
        chk("t2_min_2", outs(), 8'h02);
        tick();
        chk("t2_min_idle", outs(), 8'h00);

        // 3a: 6 requests over 3 cycles, backlog peaks at 3, all 6 issued
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) begin
                rx(8'h73);
                i_btn_sec = 1'b1;
            end else begin
                idle_inputs();
            end
            tick();
            cnt += 32'(o_sec_plus);
        end
        idle_inputs();
        chk("t3_six_req", 8'(cnt), 8'd6);

        // 3b: 8 requests over 4 cycles, one dropped at saturation
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin
                rx(8'h53);
                i_btn_sec = 1'b1;
            end else begin
                idle_inputs();
            end
            tick();
            cnt += 32'(o_sec_plus);
        end
        idle_inputs();
        chk("t3_saturate", 8'(cnt), 8'd7);

        // 4: mode gating and toggling
        rx(8'h77);
        tick();
        idle_inputs();
        chk("t4_mode_sw", outs(), 8'h20);
        rx(8'h68);
        tick();
        idle_inputs();
        chk("t4_hour_gated", outs(), 8'h20);
        rx(8'h72);
        tick();
        idle_inputs();
        chk("t4_run", outs(), 8'h28);
        tick();
        chk("t4_run_done", outs(), 8'h20);
        rx(8'h43);
        tick();
        idle_inputs();
        chk("t4_clear", outs(), 8'h30);
        i_btn_sec = 1'b1;
        tick();
        idle_inputs();
        chk("t4_btn_sec_gated", outs(), 8'h20);
        rx(8'h77);
        i_btn_mode = 1'b1;
        tick();
        idle_inputs();
        chk("t4_single_toggle", outs(), 8'h00);
        tick();
        chk("t4_mode_stable", outs(), 8'h00);

        // 5: reset in the middle of a sec backlog
        for (int i = 0; i < 2; i++) begin
            rx(8'h73);
            i_btn_sec = 1'b1;
            tick();
        end
        idle_inputs();
        chk("t5_draining", outs(), 8'h01);
        rst = 1'b0;
        #1;
        chk("t5_async_clear", outs(), 8'h00);
        tick();
        tick();
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt += 32'(o_sec_plus);
        end
        chk("t5_no_leak", 8'(cnt), 8'd0);

`ifdef WATCH_CMD_ECHO_EN
        // 6: echo path
        rx(8'h77);
        tick();
        idle_inputs();
        chk("t6_mode_sw", outs(), 8'h20);
        wait_start("t6_w", 8'h77);
        tx_handshake();
        rx(8'h63);
        tick();
        idle_inputs();
        chk("t6_clear", outs(), 8'h30);
        wait_start("t6_c", 8'h63);
        tx_handshake();
        i_tx_busy = 1'b1;
        tick();
        rx(8'h72);
        tick();
        idle_inputs();
        chk("t6_run", outs(), 8'h28);
        rx(8'h43);
        tick();
        idle_inputs();
        chk("t6_clear_full_buf", outs(), 8'h30);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cnt += 32'(o_tx_start);
        end
        chk("t6_hold_busy", 8'(cnt), 8'd0);
        i_tx_busy = 1'b0;
        wait_start("t6_r", 8'h72);
        tx_handshake();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cnt += 32'(o_tx_start);
        end
        chk("t6_third_dropped", 8'(cnt), 8'd0);
`else
        rx(8'h77);
        tick();
        idle_inputs();
        chk("noecho_mode", outs(), 8'h20);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt += 32'(o_tx_start);
            if (o_tx_data != 8'h00) cnt++;
        end
        chk("noecho_quiet", 8'(cnt), 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
